uart_program_loader: RTL



---
 rtl/uart_program_loader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : uart_program_loader
// Brief   : UART boot loader; fills program memory, replies ACK/NAK, releases CPU.
// Revision: 1.0
// ============================================================================
module uart_program_loader #(
  parameter int NB_INSTRUC = 16,
  parameter int NB_ADDR    = 11,
  parameter int RAM_DEPTH  = 2048,
  parameter int DBIT       = 8,
  parameter logic [DBIT-1:0] START_CMD = 8'hA5,
  parameter logic [DBIT-1:0] ACK_BYTE  = 8'h06,
  parameter logic [DBIT-1:0] NAK_BYTE  = 8'h15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DBIT-1:0]       i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [DBIT-1:0]       o_tx_data,
  output logic                  o_wr_en,
  output logic [NB_ADDR-1:0]    o_wr_addr,
  output logic [NB_INSTRUC-1:0] o_wr_data,
  output logic                  o_cpu_hold,
  output logic                  o_done,
  output logic                  o_error
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_CHECK   = 4'd5,
    ST_SEND    = 4'd6,
    ST_WAIT_TX = 4'd7,
    ST_RUN     = 4'd8
  } state_t;

  localparam logic [NB_INSTRUC-1:0] C_DEPTH    = NB_INSTRUC'(RAM_DEPTH);
  localparam logic [NB_INSTRUC-1:0] C_CNT_ONE  = NB_INSTRUC'(1);
  localparam logic [NB_ADDR-1:0]    C_ADDR_ONE = NB_ADDR'(1);

  state_t                r_state_q,    w_state_d;
  logic [DBIT-1:0]       r_len_hi_q,   w_len_hi_d;
  logic [DBIT-1:0]       r_hi_q,       w_hi_d;
  logic [DBIT-1:0]       r_chk_q,      w_chk_d;
  logic [NB_INSTRUC-1:0] r_cnt_q,      w_cnt_d;
  logic [NB_ADDR-1:0]    r_addr_q,     w_addr_d;
  logic                  r_ack_q,      w_ack_d;
  logic                  r_wr_en_q,    w_wr_en_d;
  logic [NB_ADDR-1:0]    r_wr_addr_q,  w_wr_addr_d;
  logic [NB_INSTRUC-1:0] r_wr_data_q,  w_wr_data_d;
  logic                  r_tx_start_q, w_tx_start_d;
  logic [DBIT-1:0]       r_tx_data_q,  w_tx_data_d;
  logic                  r_cpu_hold_q, w_cpu_hold_d;
  logic                  r_done_q,     w_done_d;
  logic                  r_error_q,    w_error_d;

  logic [NB_INSTRUC-1:0] w_len;
  assign w_len = {r_len_hi_q, i_rx_data};

  always_comb begin
    w_state_d    = r_state_q;
    w_len_hi_d   = r_len_hi_q;
    w_hi_d       = r_hi_q;
    w_chk_d      = r_chk_q;
    w_cnt_d      = r_cnt_q;
    w_addr_d     = r_addr_q;
    w_ack_d      = r_ack_q;
    w_wr_en_d    = 1'b0;
    w_wr_addr_d  = r_wr_addr_q;
    w_wr_data_d  = r_wr_data_q;
    w_tx_start_d = 1'b0;
    w_tx_data_d  = r_tx_data_q;
    w_cpu_hold_d = r_cpu_hold_q;
    w_done_d     = r_done_q;
    w_error_d    = r_error_q;
    case (r_state_q)
      ST_IDLE: begin
        if (i_rx_done && i_rx_data == START_CMD) begin
          w_error_d = 1'b0;
          w_state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (i_rx_done) begin
          w_len_hi_d = i_rx_data;
          w_state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (i_rx_done) begin
          if (w_len == '0 || w_len > C_DEPTH) begin
            w_tx_data_d = NAK_BYTE;
            w_ack_d     = 1'b0;
            w_state_d   = ST_SEND;
          end else begin
            w_cnt_d   = w_len;
            w_addr_d  = '0;
            w_chk_d   = '0;
            w_state_d = ST_DATA_HI;
          end
        end
      end
      ST_DATA_HI: begin
        if (i_rx_done) begin
          w_hi_d    = i_rx_data;
          w_chk_d   = r_chk_q ^ i_rx_data;
          w_state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (i_rx_done) begin
          w_wr_en_d   = 1'b1;
          w_wr_addr_d = r_addr_q;
          w_wr_data_d = {r_hi_q, i_rx_data};
          w_chk_d     = r_chk_q ^ i_rx_data;
          w_addr_d    = r_addr_q + C_ADDR_ONE;
          w_cnt_d     = r_cnt_q - C_CNT_ONE;
          w_state_d   = (r_cnt_q == C_CNT_ONE) ? ST_CHECK : ST_DATA_HI;
        end
      end
      ST_CHECK: begin
        if (i_rx_done) begin
          w_ack_d     = (i_rx_data == r_chk_q);
          w_tx_data_d = (i_rx_data == r_chk_q) ? ACK_BYTE : NAK_BYTE;
          w_state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        w_tx_start_d = 1'b1;
        w_state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        // Received bytes are dropped here; only the transmitter matters.
        if (i_tx_done) begin
          if (r_ack_q) begin
            w_cpu_hold_d = 1'b0;
            w_done_d     = 1'b1;
            w_state_d    = ST_RUN;
          end else begin
            w_error_d = 1'b1;
            w_state_d = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        if (i_rx_done && i_rx_data == START_CMD) begin
          w_cpu_hold_d = 1'b1;
          w_done_d     = 1'b0;
          w_error_d    = 1'b0;
          w_state_d    = ST_LEN_HI;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state_q    <= ST_IDLE;
      r_len_hi_q   <= '0;
      r_hi_q       <= '0;
      r_chk_q      <= '0;
      r_cnt_q      <= '0;
      r_addr_q     <= '0;
      r_ack_q      <= 1'b0;
      r_wr_en_q    <= 1'b0;
      r_wr_addr_q  <= '0;
      r_wr_data_q  <= '0;
      r_tx_start_q <= 1'b0;
      r_tx_data_q  <= '0;
      r_cpu_hold_q <= 1'b1;
      r_done_q     <= 1'b0;
      r_error_q    <= 1'b0;
    end else begin
      r_state_q    <= w_state_d;
      r_len_hi_q   <= w_len_hi_d;
      r_hi_q       <= w_hi_d;
      r_chk_q      <= w_chk_d;
      r_cnt_q      <= w_cnt_d;
      r_addr_q     <= w_addr_d;
      r_ack_q      <= w_ack_d;
      r_wr_en_q    <= w_wr_en_d;
      r_wr_addr_q  <= w_wr_addr_d;
      r_wr_data_q  <= w_wr_data_d;
      r_tx_start_q <= w_tx_start_d;
      r_tx_data_q  <= w_tx_data_d;
      r_cpu_hold_q <= w_cpu_hold_d;
      r_done_q     <= w_done_d;
      r_error_q    <= w_error_d;
    end
  end

  assign o_wr_en    = r_wr_en_q;
  assign o_wr_addr  = r_wr_addr_q;
  assign o_wr_data  = r_wr_data_q;
  assign o_tx_start = r_tx_start_q;
  assign o_tx_data  = r_tx_data_q;
  assign o_cpu_hold = r_cpu_hold_q;
  assign o_done     = r_done_q;
  assign o_error    = r_error_q;

endmodule
`default_nettype wire
